// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory pipeline stage with a valid/ready request port and a response port.
// Ports: execute-side bundle (m_valid/m_ready plus *_m fields), data memory request (dm_req_*,
//        dm_we/addr/wdata/be), data memory response (dm_rsp_*), writeback bundle (w_valid plus *_w).
// Latency: 1 cycle for non-memory ops and for misaligned/illegal accesses. Memory ops take at least
//          3 cycles to the response, plus 1 cycle to w_valid. m_ready is high only while idle.
module mem_stage_hs #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic                 reg_write_m,
    input  logic                 mem_read_m,
    input  logic                 mem_write_m,
    input  logic [1:0]           result_src_m,
    input  logic [2:0]           funct3_m,
    input  logic [RD_W-1:0]      rd_m,
    input  logic [XLEN-1:0]      pc_plus4_m,
    input  logic [XLEN-1:0]      alu_result_m,
    input  logic [XLEN-1:0]      write_data_m,
    output logic                 dm_req_valid,
    input  logic                 dm_req_ready,
    output logic                 dm_we,
    output logic [XLEN-1:0]      dm_addr,
    output logic [XLEN-1:0]      dm_wdata,
    output logic [XLEN/8-1:0]    dm_be,
    input  logic                 dm_rsp_valid,
    input  logic [XLEN-1:0]      dm_rsp_rdata,
    output logic                 w_valid,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_w,
    output logic [RD_W-1:0]      rd_w,
    output logic [XLEN-1:0]      pc_plus4_w,
    output logic [XLEN-1:0]      alu_result_w,
    output logic [XLEN-1:0]      read_data_w,
    output logic                 misalign_w
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_nxt;

    // Bundle held while the memory access is in flight; copied to the *_w outputs
    // only at completion so the writeback outputs hold until the next capture.
    logic              reg_write_q;
    logic [1:0]        result_src_q;
    logic [RD_W-1:0]   rd_q;
    logic [XLEN-1:0]   pc_plus4_q;
    logic [XLEN-1:0]   alu_result_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;

    logic              accept;
    logic              is_mem;
    logic              is_store;
    logic              bad_access;
    logic [OFF_W-1:0]  off_m;
    logic [XLEN-1:0]   wdata_lane;
    logic [BE_W-1:0]   be_lane;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_data;

    // Gated by rst so every output reads 0 while reset is held.
    assign m_ready      = rst && (state == IDLE);
    assign dm_req_valid = (state == REQ);
    assign accept       = m_ready && m_valid;
    assign is_mem       = mem_read_m || mem_write_m;
    assign is_store     = mem_write_m;  // a store wins when both flags are set
    assign off_m        = alu_result_m[OFF_W-1:0];

    // Alignment and size legality; D and WU do not exist on a 32-bit datapath.
    always_comb begin
        bad_access = 1'b0;
        case (funct3_m)
            3'b000, 3'b100: bad_access = 1'b0;
            3'b001, 3'b101: bad_access = off_m[0];
            3'b010:         bad_access = (off_m[1:0] != 2'b00);
            3'b110:         bad_access = (XLEN == 32) || (off_m[1:0] != 2'b00);
            3'b011:         bad_access = (XLEN == 32) || (off_m != '0);
            default:        bad_access = 1'b1;
        endcase
    end

    // Store data is replicated across every lane so the byte enables alone pick the target.
    always_comb begin
        wdata_lane = write_data_m;
        be_lane    = '1;
        case (funct3_m[1:0])
            2'b00: begin
                wdata_lane = {BE_W{write_data_m[7:0]}};
                be_lane    = BE_W'(1) << off_m;
            end
            2'b01: begin
                wdata_lane = {(BE_W/2){write_data_m[15:0]}};
                be_lane    = BE_W'(3) << off_m;
            end
            2'b10: begin
                wdata_lane = {(XLEN/32){write_data_m[31:0]}};
                be_lane    = BE_W'(15) << off_m;
            end
            default: begin
                wdata_lane = write_data_m;
                be_lane    = '1;
            end
        endcase
    end

    // Load lane extraction from the raw aligned word.
    assign shifted = dm_rsp_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = dm_rsp_rdata;
        case (funct3_q)
            3'b000:  load_data = XLEN'($signed(shifted[7:0]));
            3'b001:  load_data = XLEN'($signed(shifted[15:0]));
            3'b010:  load_data = XLEN'($signed(shifted[31:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b101:  load_data = XLEN'(shifted[15:0]);
            3'b110:  load_data = XLEN'(shifted[31:0]);
            default: load_data = dm_rsp_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mem && !bad_access) state_nxt = REQ;
            REQ:     if (dm_req_ready) state_nxt = WAIT;
            WAIT:    if (dm_rsp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            alu_result_q <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            dm_be        <= '0;
            w_valid      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= '0;
            rd_w         <= '0;
            pc_plus4_w   <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            misalign_w   <= 1'b0;
        end else begin
            w_valid <= 1'b0;
            if (accept) begin
                if (!is_mem || bad_access) begin
                    // Completes immediately; a rejected access never writes a register.
                    w_valid      <= 1'b1;
                    reg_write_w  <= reg_write_m && !is_mem;
                    result_src_w <= result_src_m;
                    rd_w         <= rd_m;
                    pc_plus4_w   <= pc_plus4_m;
                    alu_result_w <= alu_result_m;
                    read_data_w  <= '0;
                    misalign_w   <= is_mem;
                end else begin
                    reg_write_q  <= reg_write_m;
                    result_src_q <= result_src_m;
                    rd_q         <= rd_m;
                    pc_plus4_q   <= pc_plus4_m;
                    alu_result_q <= alu_result_m;
                    funct3_q     <= funct3_m;
                    off_q        <= off_m;
                    dm_we        <= is_store;
                    dm_addr      <= {alu_result_m[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    dm_wdata     <= is_store ? wdata_lane : '0;
                    dm_be        <= is_store ? be_lane : '0;
                end
            end
            if (state == WAIT && dm_rsp_valid) begin
                w_valid      <= 1'b1;
                reg_write_w  <= reg_write_q;
                result_src_w <= result_src_q;
                rd_w         <= rd_q;
                pc_plus4_w   <= pc_plus4_q;
                alu_result_w <= alu_result_q;
                read_data_w  <= dm_we ? '0 : load_data;
                misalign_w   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;
    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid, m_ready;
    logic        reg_write_m, mem_read_m, mem_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [4:0]  rd_m;
    logic [31:0] pc_plus4_m, alu_result_m, write_data_m;
    logic        dm_req_valid, dm_req_ready, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        w_valid, reg_write_w;
    logic [1:0]  result_src_w;
    logic [4:0]  rd_w;
    logic [31:0] pc_plus4_w, alu_result_w, read_data_w;
    logic        misalign_w;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_hs #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_ready(m_ready),
        .reg_write_m(reg_write_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .result_src_m(result_src_m), .funct3_m(funct3_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
        .w_valid(w_valid), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
        .rd_w(rd_w), .pc_plus4_w(pc_plus4_w), .alu_result_w(alu_result_w),
        .read_data_w(read_data_w), .misalign_w(misalign_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
        m_valid      = 1'b1;
        reg_write_m  = rw;
        mem_read_m   = mr;
        mem_write_m  = mw;
        result_src_m = mr ? 2'b01 : 2'b00;
        funct3_m     = f3;
        rd_m         = rd;
        alu_result_m = alu;
        pc_plus4_m   = alu + 32'd4;
        write_data_m = wd;
    endtask

    // Accept, zero-wait grant, response with the given word; leaves outputs at the w_valid cycle.
    task automatic mem_cycle(input logic [31:0] rdata);
        step();
        m_valid      = 1'b0;
        dm_req_ready = 1'b1;
        step();
        dm_req_ready = 1'b0;
        dm_rsp_valid = 1'b1;
        dm_rsp_rdata = rdata;
        step();
        dm_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        m_valid = 1'b0; reg_write_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
        result_src_m = '0; funct3_m = '0; rd_m = '0;
        pc_plus4_m = '0; alu_result_m = '0; write_data_m = '0;
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_rdata = '0;

        // Reset state
        #12;
        chk("rst_m_ready", m_ready, 0);
        chk("rst_req_valid", dm_req_valid, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_be", dm_be, 0);
        chk("rst_misalign", misalign_w, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("idle_m_ready", m_ready, 1);

        // ALU op: single-cycle writeback
        drive(1, 0, 0, 3'b000, 5'd5, 32'h1234, 32'h0);
        step();
        m_valid = 1'b0;
        chk("alu_w_valid", w_valid, 1);
        chk("alu_rd_w", rd_w, 5);
        chk("alu_result_w", alu_result_w, 32'h1234);
        chk("alu_pc_plus4_w", pc_plus4_w, 32'h1238);
        chk("alu_reg_write_w", reg_write_w, 1);
        chk("alu_req_valid", dm_req_valid, 0);
        step();
        chk("alu_w_pulse_end", w_valid, 0);
        chk("alu_rd_hold", rd_w, 5);

        // LB at 0x1003, step through each phase
        drive(1, 1, 0, 3'b000, 5'd7, 32'h1003, 32'h0);
        step();
        m_valid = 1'b0;
        chk("lb_req_valid", dm_req_valid, 1);
        chk("lb_m_ready", m_ready, 0);
        chk("lb_addr", dm_addr, 32'h1000);
        chk("lb_be", dm_be, 4'b0000);
        chk("lb_we", dm_we, 0);
        dm_req_ready = 1'b1;
        step();
        dm_req_ready = 1'b0;
        chk("lb_wait_req_valid", dm_req_valid, 0);
        chk("lb_wait_w_valid", w_valid, 0);
        dm_rsp_valid = 1'b1;
        dm_rsp_rdata = 32'h80FF_FFFF;
        step();
        dm_rsp_valid = 1'b0;
        chk("lb_w_valid", w_valid, 1);
        chk("lb_read_data", read_data_w, 32'hFFFF_FF80);
        chk("lb_rd_w", rd_w, 7);
        chk("lb_result_src_w", result_src_w, 2'b01);
        chk("lb_m_ready", m_ready, 1);

        // LBU at 0x1003
        drive(1, 1, 0, 3'b100, 5'd8, 32'h1003, 32'h0);
        mem_cycle(32'h80FF_FFFF);
        chk("lbu_w_valid", w_valid, 1);
        chk("lbu_read_data", read_data_w, 32'h0000_0080);

        // LH at 0x1002 and LHU at 0x1002
        drive(1, 1, 0, 3'b001, 5'd9, 32'h1002, 32'h0);
        mem_cycle(32'h8001_1234);
        chk("lh_read_data", read_data_w, 32'hFFFF_8001);
        drive(1, 1, 0, 3'b101, 5'd9, 32'h1002, 32'h0);
        mem_cycle(32'h8001_1234);
        chk("lhu_read_data", read_data_w, 32'h0000_8001);

        // LW aligned
        drive(1, 1, 0, 3'b010, 5'd10, 32'h1004, 32'h0);
        mem_cycle(32'hDEAD_BEEF);
        chk("lw_read_data", read_data_w, 32'hDEAD_BEEF);
        chk("lw_misalign", misalign_w, 0);

        // SH at 0x1002 data 0xABCD
        drive(0, 0, 1, 3'b001, 5'd0, 32'h1002, 32'h0000_ABCD);
        step();
        m_valid = 1'b0;
        chk("sh_addr", dm_addr, 32'h1000);
        chk("sh_be", dm_be, 4'b1100);
        chk("sh_wdata", dm_wdata, 32'hABCD_ABCD);
        chk("sh_we", dm_we, 1);
        dm_req_ready = 1'b1;
        step();
        dm_req_ready = 1'b0;
        step();
        chk("sh_no_w_before_rsp", w_valid, 0);
        dm_rsp_valid = 1'b1;
        step();
        dm_rsp_valid = 1'b0;
        chk("sh_w_valid", w_valid, 1);
        chk("sh_read_data", read_data_w, 0);

        // SB at 0x2001
        drive(0, 0, 1, 3'b000, 5'd0, 32'h2001, 32'h0000_005A);
        step();
        m_valid = 1'b0;
        chk("sb_be", dm_be, 4'b0010);
        chk("sb_wdata", dm_wdata, 32'h5A5A_5A5A);
        dm_req_ready = 1'b1;
        step();
        dm_req_ready = 1'b0;
        dm_rsp_valid = 1'b1;
        step();
        dm_rsp_valid = 1'b0;

        // LW at 0x1001: misaligned, no request
        drive(1, 1, 0, 3'b010, 5'd11, 32'h1001, 32'h0);
        step();
        m_valid = 1'b0;
        chk("mis_w_valid", w_valid, 1);
        chk("mis_flag", misalign_w, 1);
        chk("mis_reg_write", reg_write_w, 0);
        chk("mis_m_ready", m_ready, 1);
        chk("mis_req_valid", dm_req_valid, 0);

        // LD on a 32-bit datapath is illegal even when aligned
        drive(1, 1, 0, 3'b011, 5'd12, 32'h1000, 32'h0);
        step();
        m_valid = 1'b0;
        chk("ld_illegal_flag", misalign_w, 1);
        chk("ld_illegal_req", dm_req_valid, 0);

        // Response while idle is ignored
        dm_rsp_valid = 1'b1;
        step();
        dm_rsp_valid = 1'b0;
        chk("idle_rsp_ignored", w_valid, 0);

        // SW with both flags set, grant withheld for 3 cycles
        drive(1, 1, 1, 3'b010, 5'd13, 32'h2004, 32'h1122_3344);
        step();
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_req_valid", dm_req_valid, 1);
            chk("stall_addr", dm_addr, 32'h2004);
            chk("stall_be", dm_be, 4'b1111);
            chk("stall_wdata", dm_wdata, 32'h1122_3344);
            chk("stall_we", dm_we, 1);
            chk("stall_m_ready", m_ready, 0);
            if (i == 3) dm_req_ready = 1'b1;
            step();
        end
        dm_req_ready = 1'b0;
        chk("stall_in_wait", dm_req_valid, 0);
        dm_rsp_valid = 1'b1;
        step();
        dm_rsp_valid = 1'b0;
        chk("stall_w_valid", w_valid, 1);
        chk("stall_read_data", read_data_w, 0);

        // Reset while waiting for a response
        drive(1, 1, 0, 3'b000, 5'd14, 32'h3000, 32'h0);
        step();
        m_valid = 1'b0;
        dm_req_ready = 1'b1;
        step();
        dm_req_ready = 1'b0;
        rst = 1'b0;
        #2;
        chk("arst_req_valid", dm_req_valid, 0);
        chk("arst_addr", dm_addr, 0);
        chk("arst_rd_w", rd_w, 0);
        chk("arst_read_data", read_data_w, 0);
        chk("arst_m_ready", m_ready, 0);
        #2;
        rst = 1'b1;
        dm_rsp_valid = 1'b1;
        dm_rsp_rdata = 32'hFFFF_FFFF;
        step();
        dm_rsp_valid = 1'b0;
        chk("arst_rsp_ignored", w_valid, 0);
        chk("arst_read_data_after", read_data_w, 0);
        chk("arst_idle", m_ready, 1);
        step();
        chk("arst_no_late_w", w_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter RD_W, default 5, destination-register index width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 m_valid  input  1  execute stage presents an operation.
REQ-006 m_ready  output  1  stage accepts operation this cycle.
REQ-007 reg_write_m, mem_read_m, mem_write_m  input  1 each  control flags.
REQ-008 result_src_m  input  2  writeback select.
REQ-009 funct3_m  input  3  access size and sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 rd_m  input  RD_W  destination register.
REQ-011 pc_plus4_m, alu_result_m, write_data_m  input  XLEN each  PC+4, address or result, store data.
REQ-012 dm_req_valid  output  1  memory request valid.
REQ-013 dm_req_ready  input  1  memory accepts request.
REQ-014 dm_we  output  1  request is a store.
REQ-015 dm_addr  output  XLEN  address, low log2(XLEN/8) bits zero.
REQ-016 dm_wdata  output  XLEN  store data shifted to byte lane.
REQ-017 dm_be  output  XLEN/8  byte enables.
REQ-018 dm_rsp_valid  input  1  read data valid or store acknowledge.
REQ-019 dm_rsp_rdata  input  XLEN  raw aligned read word.
REQ-020 w_valid  output  1  one-cycle pulse: writeback bundle valid.
REQ-021 reg_write_w, result_src_w, rd_w, pc_plus4_w, alu_result_w  output  widths as inputs  registered copies.
REQ-022 read_data_w  output  XLEN  lane-extracted, sign- or zero-extended load data.
REQ-023 misalign_w  output  1  access was misaligned or illegal size; no memory request issued.

Function
REQ-024 FSM states IDLE, REQ, WAIT; m_ready SHALL be 1 only in IDLE.
REQ-025 IDLE, m_valid, neither mem flag: capture bundle; w_valid and outputs next cycle; latency 1; stay IDLE.
REQ-026 IDLE, m_valid, memory op, aligned: capture address, data, funct3, control; go to REQ.
REQ-027 Misalignment: H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0; funct3 011/110 with XLEN=32, or 111, is illegal.
REQ-028 Misaligned or illegal: no request; next cycle w_valid=1, misalign_w=1, reg_write_w=0; stay IDLE.
REQ-029 REQ: dm_req_valid=1; dm_addr, dm_we, dm_wdata, dm_be stable until dm_req_ready=1 on a rising edge; then go to WAIT.
REQ-030 WAIT: on dm_rsp_valid=1, latch lane-extracted data; next cycle w_valid=1; go to IDLE.
REQ-031 Store: dm_be has 1/2/4/8 ones at the address offset; write_data low bits replicated to that lane; read_data_w=0.
REQ-032 Load: select bytes at offset; sign-extend for B/H/W, zero-extend for BU/HU/WU; D passes through.
REQ-033 dm_rsp_valid outside WAIT is ignored.
REQ-034 Both mem_read_m and mem_write_m set: treated as store.
REQ-035 w_valid is exactly one cycle per accepted operation; outputs other than w_valid hold until next capture.
REQ-036 Minimum memory-op latency 3 cycles (accept, request, response with zero-wait memory), plus 1 cycle to w_valid.

Reset
REQ-037 rst low: state IDLE; all outputs 0, including dm_req_valid, w_valid, misalign_w, dm_be.
REQ-038 rst asserted during REQ or WAIT: request dropped; a later dm_rsp_valid is ignored.

Verification
REQ-039 ALU op, rd=5, alu_result=0x1234 -> next cycle w_valid=1, rd_w=5, alu_result_w=0x1234, dm_req_valid never 1.
REQ-040 LB at 0x1003, rdata=0x80FF_FFFF -> dm_be=0000 (read), read_data_w=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-041 SH at 0x1002, data 0xABCD -> dm_addr=0x1000, dm_be=1100, dm_wdata=0xABCD_ABCD; w_valid after dm_rsp_valid.
REQ-042 LW at 0x1001 -> no request, w_valid=1, misalign_w=1, reg_write_w=0, m_ready stays 1.
REQ-043 dm_req_ready low 3 cycles -> request fields stable 4 cycles, m_ready=0 throughout.
REQ-044 rst asserted in WAIT, then dm_rsp_valid pulse -> all outputs 0, no w_valid, state IDLE.
